mat2_seq: RTL and testbench

Sequenced 2x2 matrix multiplier controller that computes Y = A x B for 8-bit unsigned elements using a single shared W x W multiplier and one 2W+1-bit accumulator.
- It is the area-reduced, time-multiplexed alternative to the fully parallel 8-multiplier / 4-adder 2x2 product datapath.
- Same packed operand and result layout as that datapath, so it drops into the same surroundings.
- Operands are taken and results returned through a valid/ready handshake.

---
 rtl/mat2_seq.sv | 135 +++++++++++++
 tb/tb_mat2_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mat2_seq.sv
// Time-multiplexed 2x2 matrix multiplier: Y = A x B with one shared W x W
// multiplier and one accumulator, eight steps per job, valid/ready on both sides.
module mat2_seq #(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*W-1:0]         a,
    input  logic [4*W-1:0]         b,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*(2*W+1)-1:0]   y,
    output logic                   busy
);

    localparam int LW = 2 * W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [2:0]      s;
    logic [4*W-1:0]  a_q;
    logic [4*W-1:0]  b_q;
    logic [LW-1:0]   acc;
    logic [LW-1:0]   y_lane [4];
    logic [W-1:0]    a_el [4];
    logic [W-1:0]    b_el [4];
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [2*W-1:0]  prod;
    logic [LW-1:0]   prod_ext;

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign a_el[i] = a_q[i*W +: W];
        assign b_el[i] = b_q[i*W +: W];
        assign y[i*LW +: LW] = y_lane[i];
    end

    // Step s picks A[r][t] (byte 2r+t) and B[t][c] (byte 2t+c), with r=s[2], c=s[1], t=s[0].
    always_comb begin
        a_sel    = a_el[{s[2], s[0]}];
        b_sel    = b_el[{s[0], s[1]}];
        prod     = a_sel * b_sel;
        prod_ext = {1'b0, prod};
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == MUL) || (state == DONE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // abort outranks both acceptance and result delivery.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid && !abort) begin
                    next_state = MUL;
                end
            end
            MUL: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (s == 3'd7) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Even steps load the first partial product; odd steps close out one lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= '0;
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            for (int i = 0; i < 4; i++) begin
                y_lane[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !abort) begin
                        a_q <= a;
                        b_q <= b;
                        s   <= '0;
                    end
                end
                MUL: begin
                    if (abort) begin
                        acc <= '0;
                        s   <= '0;
                    end else begin
                        s <= s + 3'd1;
                        if (!s[0]) begin
                            acc <= prod_ext;
                        end else begin
                            y_lane[s[2:1]] <= acc + prod_ext;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        acc <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat2_seq.sv
// Directed self-checking bench for mat2_seq: identity, general, max-value,
// backpressure, abort and asynchronous-reset jobs with hand-computed lanes.
module tb_mat2_seq;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   a;
    logic [31:0]   b;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [67:0]   y;
    logic          busy;

    int            checks;
    int            errors;
    int            cycles;
    int            seen_valid;
    logic [67:0]   ysave;

    mat2_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [67:0] lanes(input int l0, input int l1, input int l2, input int l3);
        return {17'(l3), 17'(l2), 17'(l1), 17'(l0)};
    endfunction

    task automatic checkOutput(input string tag, input logic [67:0] observed, input logic [67:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one operand pair for a single edge, returning at the negedge after it.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        #12;
        checkOutput("reset_out_valid", 68'(out_valid), 68'd0);
        checkOutput("reset_busy", 68'(busy), 68'd0);
        checkOutput("reset_in_ready", 68'(in_ready), 68'd1);
        checkOutput("reset_y", y, 68'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity A times B returns B
        applyStimulus(32'h01000001, 32'h05040302);
        checkOutput("ident_busy", 68'(busy), 68'd1);
        checkOutput("ident_in_ready", 68'(in_ready), 68'd0);
        waitResult(cycles);
        checkOutput("ident_latency", 68'(cycles), 68'd8);
        checkOutput("ident_y", y, lanes(2, 3, 4, 5));
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("ident_release_in_ready", 68'(in_ready), 68'd1);
        checkOutput("ident_release_out_valid", 68'(out_valid), 68'd0);

        // General product with out_ready held high: one-cycle out_valid
        applyStimulus(32'h04030201, 32'h08070605);
        waitResult(cycles);
        checkOutput("gen_latency", 68'(cycles), 68'd8);
        checkOutput("gen_y", y, lanes(19, 22, 43, 50));
        @(negedge clk);
        checkOutput("gen_pulse_out_valid", 68'(out_valid), 68'd0);
        checkOutput("gen_pulse_in_ready", 68'(in_ready), 68'd1);
        out_ready = 1'b0;

        // Max operands, then backpressure with fresh operands offered
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
        waitResult(cycles);
        checkOutput("max_latency", 68'(cycles), 68'd8);
        checkOutput("max_y", y, lanes(130050, 130050, 130050, 130050));
        ysave    = y;
        a        = 32'h04030201;
        b        = 32'h08070605;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 68'(out_valid), 68'd1);
            checkOutput("bp_in_ready", 68'(in_ready), 68'd0);
            checkOutput("bp_y_stable", y, ysave);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", 68'(in_ready), 68'd1);
        checkOutput("bp_release_busy", 68'(busy), 68'd0);
        out_ready = 1'b0;
        applyStimulus(32'h01000001, 32'h0A0B0C0D);
        waitResult(cycles);
        checkOutput("bp_next_latency", 68'(cycles), 68'd8);
        checkOutput("bp_next_y", y, lanes(13, 12, 11, 10));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Abort while s=3 is about to execute: only lane 0 was rewritten
        applyStimulus(32'h01000001, 32'h05040302);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_in_ready", 68'(in_ready), 68'd1);
        checkOutput("abort_busy", 68'(busy), 68'd0);
        checkOutput("abort_y_kept", y, lanes(2, 12, 11, 10));
        seen_valid = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        checkOutput("abort_no_valid", 68'(seen_valid), 68'd0);
        applyStimulus(32'h01000001, 32'h08070605);
        waitResult(cycles);
        checkOutput("abort_next_latency", 68'(cycles), 68'd8);
        checkOutput("abort_next_y", y, lanes(5, 6, 7, 8));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset between edges while s=5
        applyStimulus(32'h04030201, 32'h08070605);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", 68'(out_valid), 68'd0);
        checkOutput("areset_busy", 68'(busy), 68'd0);
        checkOutput("areset_in_ready", 68'(in_ready), 68'd1);
        checkOutput("areset_y", y, 68'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'h04030201, 32'h08070605);
        waitResult(cycles);
        checkOutput("areset_next_latency", 68'(cycles), 68'd8);
        checkOutput("areset_next_y", y, lanes(19, 22, 43, 50));
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("final_in_ready", 68'(in_ready), 68'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
